// File: rtl/pmod_seq_pkg.sv
// Shared types and constants for the PMOD mode sequencer and its arbiter.
package pmod_seq_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_QUIET = 2'd1,
    ISOLATE    = 2'd2
  } seq_state_e;

  localparam logic [1:0] MODE_GPIO = 2'd0;
  localparam logic [1:0] MODE_UART = 2'd1;
  localparam logic [1:0] MODE_SPI  = 2'd2;
  localparam logic [1:0] MODE_I2C  = 2'd3;

  // Port index is fixed at two bits; at most four ports are supported.
  localparam int PORT_IDX_W = 2;

  function automatic logic [PORT_IDX_W-1:0] next_port(input logic [PORT_IDX_W-1:0] p,
                                                      input int n);
    if (int'(p) >= n - 1) return '0;
    return p + 1'b1;
  endfunction

endpackage

// File: rtl/pmod_mode_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: first pending index at or after rr_ptr, wrapping.
module rr_arbiter
  import pmod_seq_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0]  pending_i,
  input  logic [PORT_IDX_W-1:0] rr_ptr_i,
  output logic                  grant_valid_o,
  output logic [PORT_IDX_W-1:0] grant_o
);

  logic                  found;
  logic [PORT_IDX_W-1:0] idx;

  always_comb begin
    found = 1'b0;
    grant_o = '0;
    idx = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx = PORT_IDX_W'((32'(rr_ptr_i) + i) % NUM_PORTS);
      if (!found && pending_i[idx]) begin
        found = 1'b1;
        grant_o = idx;
      end
    end
    grant_valid_o = found;
  end

endmodule

// File: rtl/pmod_mode_sequencer.sv
// Break-before-make sequencer: waits for port quiet, isolates for a guard time, applies new mode.
module pmod_mode_sequencer
  import pmod_seq_pkg::*;
#(
  parameter int NUM_PORTS     = 4,
  parameter int GUARD_CYCLES  = 100,
  parameter int QUIET_TIMEOUT = 1000000,
  parameter int CNT_W         = 20
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [2*NUM_PORTS-1:0] req_mode,
  input  logic [NUM_PORTS-1:0]   port_busy,
  input  logic                   clear_timeout,
  output logic [2*NUM_PORTS-1:0] mode_applied,
  output logic [NUM_PORTS-1:0]   isolate,
  output logic                   change_done,
  output logic [1:0]             done_port,
  output logic [NUM_PORTS-1:0]   timeout_flag,
  output logic                   seq_active
);

  seq_state_e             state_q, state_d;
  logic [PORT_IDX_W-1:0]  sel_q, sel_d;
  logic [PORT_IDX_W-1:0]  rr_q, rr_d;
  logic [1:0]             target_q, target_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2*NUM_PORTS-1:0] mode_q, mode_d;
  logic [NUM_PORTS-1:0]   iso_q, iso_d;
  logic [NUM_PORTS-1:0]   tflag_q, tflag_d;
  logic                   done_q, done_d;
  logic [1:0]             done_port_q, done_port_d;
  logic                   active_q;

  logic [NUM_PORTS-1:0]   pending;
  logic                   grant_valid;
  logic [PORT_IDX_W-1:0]  grant;

  always_comb begin
    for (int unsigned k = 0; k < NUM_PORTS; k++)
      pending[k] = (req_mode[2*k +: 2] != mode_q[2*k +: 2]);
  end

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .pending_i    (pending),
    .rr_ptr_i     (rr_q),
    .grant_valid_o(grant_valid),
    .grant_o      (grant)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rr_d        = rr_q;
    target_d    = target_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    tflag_d     = tflag_q;
    done_d      = 1'b0;
    done_port_d = done_port_q;
    // Clear first so a same-cycle timeout set overrides it.
    if (clear_timeout) tflag_d = '0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          sel_d    = grant;
          target_d = req_mode[{grant, 1'b0} +: 2];
          cnt_d    = '0;
          state_d  = WAIT_QUIET;
        end
      end
      WAIT_QUIET: begin
        if (req_mode[{sel_q, 1'b0} +: 2] == mode_q[{sel_q, 1'b0} +: 2]) begin
          state_d = IDLE;
        end else if (!port_busy[sel_q]) begin
          cnt_d   = '0;
          state_d = ISOLATE;
        end else if (cnt_q == CNT_W'(QUIET_TIMEOUT - 1)) begin
          tflag_d[sel_q] = 1'b1;
          cnt_d   = '0;
          state_d = ISOLATE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ISOLATE: begin
        if (cnt_q == CNT_W'(GUARD_CYCLES - 1)) begin
          mode_d[{sel_q, 1'b0} +: 2] = target_q;
          done_d      = 1'b1;
          done_port_d = sel_q;
          rr_d        = next_port(sel_q, NUM_PORTS);
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    iso_d = '0;
    if (state_d == ISOLATE) iso_d[sel_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      rr_q        <= '0;
      target_q    <= '0;
      cnt_q       <= '0;
      mode_q      <= '0;
      iso_q       <= '0;
      tflag_q     <= '0;
      done_q      <= 1'b0;
      done_port_q <= '0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_q        <= rr_d;
      target_q    <= target_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      iso_q       <= iso_d;
      tflag_q     <= tflag_d;
      done_q      <= done_d;
      done_port_q <= done_port_d;
      active_q    <= (state_d != IDLE);
    end
  end

  assign mode_applied = mode_q;
  assign isolate      = iso_q;
  assign change_done  = done_q;
  assign done_port    = done_port_q;
  assign timeout_flag = tflag_q;
  assign seq_active   = active_q;

endmodule

// File: tb/tb_pmod_mode_sequencer.sv
// Directed bench: dut_a uses a long quiet timeout, dut_b a 20-cycle one; both share stimulus.
module tb_pmod_mode_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] req_mode = '0;
  logic [3:0] port_busy = '0;
  logic       clear_timeout = 1'b0;

  logic [7:0] mode_a, mode_b;
  logic [3:0] iso_a, iso_b, tflag_a, tflag_b;
  logic       done_a, done_b, act_a, act_b;
  logic [1:0] dport_a, dport_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pmod_mode_sequencer #(.NUM_PORTS(4), .GUARD_CYCLES(4), .QUIET_TIMEOUT(1000), .CNT_W(20)) dut_a (
    .clk(clk), .reset_n(reset_n), .req_mode(req_mode), .port_busy(port_busy),
    .clear_timeout(clear_timeout), .mode_applied(mode_a), .isolate(iso_a),
    .change_done(done_a), .done_port(dport_a), .timeout_flag(tflag_a), .seq_active(act_a)
  );

  pmod_mode_sequencer #(.NUM_PORTS(4), .GUARD_CYCLES(4), .QUIET_TIMEOUT(20), .CNT_W(20)) dut_b (
    .clk(clk), .reset_n(reset_n), .req_mode(req_mode), .port_busy(port_busy),
    .clear_timeout(clear_timeout), .mode_applied(mode_b), .isolate(iso_b),
    .change_done(done_b), .done_port(dport_b), .timeout_flag(tflag_b), .seq_active(act_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_mode = '0;
    port_busy = '0;
    clear_timeout = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({mode_a, iso_a, done_a, dport_a, tflag_a, act_a} !== 20'h0) begin
      bad++;
      $display("FAIL reset_a got=%h exp=0", {mode_a, iso_a, done_a, dport_a, tflag_a, act_a});
    end
    total++;
    if ({mode_b, iso_b, done_b, dport_b, tflag_b, act_b} !== 20'h0) begin
      bad++;
      $display("FAIL reset_b got=%h exp=0", {mode_b, iso_b, done_b, dport_b, tflag_b, act_b});
    end
  endtask

  task automatic test_quiet_change();
    logic [3:0] ei;
    logic [7:0] em;
    req_mode = 8'h08;
    for (int t = 1; t <= 7; t++) begin
      tick();
      ei = (t >= 2 && t <= 5) ? 4'b0010 : 4'b0000;
      em = (t >= 6) ? 8'h08 : 8'h00;
      total++;
      if (iso_a !== ei) begin bad++; $display("FAIL quiet_iso t=%0d got=%b exp=%b", t, iso_a, ei); end
      total++;
      if (mode_a !== em) begin bad++; $display("FAIL quiet_mode t=%0d got=%h exp=%h", t, mode_a, em); end
      total++;
      if (done_a !== (t == 6)) begin bad++; $display("FAIL quiet_done t=%0d got=%b exp=%b", t, done_a, (t == 6)); end
      if (t == 6) begin
        total++;
        if (dport_a !== 2'd1) begin bad++; $display("FAIL quiet_dport got=%0d exp=1", dport_a); end
      end
    end
    total++;
    if (tflag_a !== 4'b0 || act_a !== 1'b0) begin
      bad++;
      $display("FAIL quiet_end tflag=%b act=%b exp tflag=0 act=0", tflag_a, act_a);
    end
  endtask

  task automatic test_busy_wait();
    logic [3:0] ei;
    logic [7:0] em;
    req_mode = 8'h09;
    port_busy = 4'b0001;
    for (int t = 1; t <= 56; t++) begin
      tick();
      if (t == 50) port_busy = 4'b0000;
      ei = (t >= 51 && t <= 54) ? 4'b0001 : 4'b0000;
      em = (t >= 55) ? 8'h09 : 8'h08;
      total++;
      if (iso_a !== ei) begin bad++; $display("FAIL busy_iso t=%0d got=%b exp=%b", t, iso_a, ei); end
      if (t == 55 || t == 54) begin
        total++;
        if (mode_a !== em) begin bad++; $display("FAIL busy_mode t=%0d got=%h exp=%h", t, mode_a, em); end
      end
    end
    total++;
    if (tflag_a !== 4'b0) begin bad++; $display("FAIL busy_tflag got=%b exp=0000", tflag_a); end
  endtask

  task automatic test_timeout();
    do_reset();
    port_busy = 4'b0100;
    req_mode = 8'h10;
    for (int t = 1; t <= 26; t++) begin
      tick();
      total++;
      if (iso_b !== ((t >= 21 && t <= 24) ? 4'b0100 : 4'b0000)) begin
        bad++; $display("FAIL tmo_iso t=%0d got=%b", t, iso_b);
      end
      total++;
      if (tflag_b !== ((t >= 21) ? 4'b0100 : 4'b0000)) begin
        bad++; $display("FAIL tmo_flag t=%0d got=%b", t, tflag_b);
      end
    end
    total++;
    if (mode_b !== 8'h10) begin bad++; $display("FAIL tmo_mode got=%h exp=10", mode_b); end
    clear_timeout = 1'b1;
    tick();
    clear_timeout = 1'b0;
    total++;
    if (tflag_b !== 4'b0) begin bad++; $display("FAIL tmo_clear got=%b exp=0000", tflag_b); end
    // Second forced change on port 2 with clear asserted on the very edge the flag sets.
    req_mode = 8'h20;
    repeat (20) tick();
    total++;
    if (tflag_b !== 4'b0 || iso_b !== 4'b0) begin
      bad++; $display("FAIL tmo2_pre tflag=%b iso=%b exp 0000 0000", tflag_b, iso_b);
    end
    clear_timeout = 1'b1;
    tick();
    clear_timeout = 1'b0;
    total++;
    if (tflag_b !== 4'b0100) begin bad++; $display("FAIL tmo_setwins got=%b exp=0100", tflag_b); end
    port_busy = 4'b0000;
    repeat (5) tick();
    total++;
    if (mode_b !== 8'h20) begin bad++; $display("FAIL tmo2_mode got=%h exp=20", mode_b); end
  endtask

  task automatic test_round_robin();
    logic [3:0] ei;
    int ndone;
    logic [1:0] order [3];
    do_reset();
    req_mode = 8'h04;
    repeat (7) tick();
    total++;
    if (mode_a !== 8'h04) begin bad++; $display("FAIL rr_setup got=%h exp=04", mode_a); end
    req_mode = 8'h55;
    ndone = 0;
    for (int t = 1; t <= 19; t++) begin
      tick();
      if (t >= 2 && t <= 5) ei = 4'b0100;
      else if (t >= 8 && t <= 11) ei = 4'b1000;
      else if (t >= 14 && t <= 17) ei = 4'b0001;
      else ei = 4'b0000;
      total++;
      if (iso_a !== ei) begin bad++; $display("FAIL rr_iso t=%0d got=%b exp=%b", t, iso_a, ei); end
      if (done_a === 1'b1) begin
        if (ndone < 3) order[ndone] = dport_a;
        ndone++;
      end
    end
    total++;
    if (ndone !== 3) begin bad++; $display("FAIL rr_count got=%0d exp=3", ndone); end
    else begin
      total++;
      if (order[0] !== 2'd2 || order[1] !== 2'd3 || order[2] !== 2'd0) begin
        bad++; $display("FAIL rr_order got=%0d,%0d,%0d exp=2,3,0", order[0], order[1], order[2]);
      end
    end
    total++;
    if (mode_a !== 8'h55) begin bad++; $display("FAIL rr_mode got=%h exp=55", mode_a); end
  endtask

  task automatic test_revert();
    do_reset();
    port_busy = 4'b1000;
    req_mode = 8'hC0;
    repeat (5) tick();
    total++;
    if (act_a !== 1'b1 || iso_a !== 4'b0) begin
      bad++; $display("FAIL rev_wait act=%b iso=%b exp 1 0000", act_a, iso_a);
    end
    req_mode = 8'h00;
    for (int t = 1; t <= 6; t++) begin
      tick();
      total++;
      if (act_a !== 1'b0 || iso_a !== 4'b0 || done_a !== 1'b0 || mode_a !== 8'h00) begin
        bad++; $display("FAIL rev_idle t=%0d act=%b iso=%b done=%b mode=%h", t, act_a, iso_a, done_a, mode_a);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_mode = 8'h08;
    repeat (3) tick();
    total++;
    if (iso_a !== 4'b0010) begin bad++; $display("FAIL mid_pre iso got=%b exp=0010", iso_a); end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (iso_a !== 4'b0 || mode_a !== 8'h00 || act_a !== 1'b0) begin
      bad++; $display("FAIL mid_async iso=%b mode=%h act=%b exp 0", iso_a, mode_a, act_a);
    end
    tick();
    reset_n = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      total++;
      if (iso_a !== ((t >= 2 && t <= 5) ? 4'b0010 : 4'b0000)) begin
        bad++; $display("FAIL mid_iso t=%0d got=%b", t, iso_a);
      end
    end
    total++;
    if (mode_a !== 8'h08 || done_a !== 1'b1 || dport_a !== 2'd1) begin
      bad++; $display("FAIL mid_done mode=%h done=%b dport=%0d exp 08 1 1", mode_a, done_a, dport_a);
    end
  endtask

  initial begin
    test_reset();
    test_quiet_change();
    test_busy_wait();
    test_timeout();
    test_round_robin();
    test_revert();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pmod_mode_sequencer.md
Name: pmod_mode_sequencer

Overview:
- Break-before-make controller for the four PMOD port muxes (UART/SPI/GPIO/I2C per connector).
- Software writes a requested 2-bit mode per port on a GPIO register. This block waits for the port's current peripheral to go quiet, isolates the connector (all pins tristated) for a guard time, then applies the new mode.
- A round-robin scheduler services one port at a time.
- Sits between the MicroBlaze GPIO and the per-port mux select/tristate inputs.

Parameters:
NUM_PORTS, 4, number of PMOD ports sequenced (index width 2 fixed; max 4)
GUARD_CYCLES, 100, cycles connector is isolated before new mode applies (1 us at 100 MHz)
QUIET_TIMEOUT, 1000000, max cycles waiting for port_busy low before forcing change (10 ms)
CNT_W, 20, width of shared wait/guard counter; must hold max(GUARD_CYCLES, QUIET_TIMEOUT)

Ports:
clk  in  1  system clock (CLK_OUT1 domain)
reset_n  in  1  asynchronous active-low reset
req_mode  in  2*NUM_PORTS  requested mode, port k at [2k+1:2k]
port_busy  in  NUM_PORTS  current peripheral active on port k (SPI SS low, UART TX shifting, I2C bus busy)
clear_timeout  in  1  synchronous clear of all timeout_flag bits
mode_applied  out  2*NUM_PORTS  mux select driven to port k muxes
isolate  out  NUM_PORTS  port k mux must tristate all four connector pins while high
change_done  out  1  one-cycle pulse when a mode change completes
done_port  out  2  index of port completed; valid with change_done
timeout_flag  out  NUM_PORTS  sticky: port k change was forced after QUIET_TIMEOUT
seq_active  out  1  high whenever state != IDLE

Behaviour:
- Clock is clk. reset_n is asynchronous and active-low. All outputs and state are registered.
- Reset values: mode_applied=0 for all ports, isolate=0, change_done=0, done_port=0, timeout_flag=0, seq_active=0, state=IDLE, rr_ptr=0, counter=0.
- pending[k] = (req_mode[k] != mode_applied[k]). This is a level compare; no edge detect.
- IDLE: if any pending, grant the first pending index at or after rr_ptr (wrapping). Latch sel=grant and target=req_mode[sel]. Clear counter. Go to WAIT_QUIET.
- WAIT_QUIET:
  - If req_mode[sel]==mode_applied[sel] (request reverted): abort to IDLE. No isolate, no done pulse; rr_ptr unchanged.
  - Else if port_busy[sel]==0: clear counter, go to ISOLATE.
  - Else if counter==QUIET_TIMEOUT-1: set timeout_flag[sel], clear counter, go to ISOLATE.
  - Else counter+1.
- ISOLATE:
  - isolate[sel]=1 for exactly GUARD_CYCLES cycles; mode_applied[sel] holds the old value throughout.
  - When counter==GUARD_CYCLES-1, on the same edge: isolate[sel]->0, mode_applied[sel]->target, change_done=1, done_port=sel, rr_ptr=(sel+1) mod NUM_PORTS, go to IDLE.
- Changes to req_mode during ISOLATE are ignored; the latched target is applied. Any residual mismatch re-pends and is sequenced again from IDLE.
- Latency with port quiet: req change at edge 0 -> WAIT_QUIET at edge 1 -> isolate high from edge 2 -> mode applied at edge 2+GUARD_CYCLES. A further grant is possible at the next edge.
- At most one isolate bit is high at any time. Non-selected ports keep mode_applied unchanged and isolate=0.
- clear_timeout and a same-cycle timeout set on the same bit: set wins.
- Reset mid-sequence: outputs return to reset values immediately (asynchronous). The change is lost; it re-pends after reset release if req_mode still differs.
- port_busy toggling during ISOLATE is ignored.

Decomposition:
- pmod_seq_pkg: state enum (IDLE, WAIT_QUIET, ISOLATE); mode constants MODE_GPIO=0, MODE_UART=1, MODE_SPI=2, MODE_I2C=3; helper for port index width.
- Sub-module rr_arbiter: pending mask + rr_ptr -> grant_valid and grant index. Purely combinational, shared with future port schedulers.

Test Plan:
- Reset, GUARD_CYCLES=4; port1 req 0->2 with busy=0 -> isolate[1] high edges 2-5, mode_applied[3:2]=2 at edge 6, change_done with done_port=1, timeout_flag=0.
- Port0 req 0->1 with port_busy[0]=1 for 50 cycles -> isolate[0] stays low until the cycle after busy falls, then the 4-cycle guard, then mode=1; no timeout.
- QUIET_TIMEOUT=20, port2 busy stuck high -> forced isolate after 20 cycles, timeout_flag[2]=1 sticky; clear_timeout pulse -> 0.
- Ports 0, 2, 3 change simultaneously with rr_ptr=2 -> service order 2, 3, 0; isolate never overlaps; three done pulses with done_port 2, 3, 0.
- Port3 req 0->3 while busy, then req reverted to 0 during WAIT_QUIET -> return to IDLE, no isolate, no change_done.
- reset_n low at guard cycle 2 of a port1 change -> isolate and mode_applied zero immediately; after release with req still 2, full sequence reruns and completes.
